fsm_control_unit_param: RTL and testbench

//  Parametrised successor control FSM for the RSA modular-exponentiation datapath (MMM core, A/R regs, muxes).

---
 rtl/fsm_control_unit_param.sv | 175 +++++++++++++++++
 tb/tb_fsm_control_unit_param.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fsm_control_unit_param.sv
// ============================================================================
// Module   : fsm_control_unit_param
// Purpose  : Sequencer for RSA modular exponentiation: map, right-to-left
//            square-and-multiply rounds, remap, with start/eoc and abort.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fsm_control_unit_param #(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = WIDTH + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 skip_lz,
    input  logic [EXP_WIDTH-1:0] expE,
    output logic                 rst_mmm,
    output logic                 ld_a,
    output logic                 ld_r,
    output logic                 lock1,
    output logic                 lock2,
    output logic [1:0]           sel1,
    output logic                 sel2,
    output logic                 busy,
    output logic                 eoc
);

    localparam int SW = $clog2(WIDTH + 3);
    localparam int RW = $clog2(EXP_WIDTH + 1);
    localparam logic [SW-1:0] c_STEP_LAST = SW'(WIDTH + 2);
    localparam logic [RW-1:0] c_ROUNDS_FULL = RW'(EXP_WIDTH);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_PRE_MAP    = 4'd1,
        S_MAP        = 4'd2,
        S_POST_MAP   = 4'd3,
        S_PRE_MMM    = 4'd4,
        S_MMM        = 4'd5,
        S_POST_MMM   = 4'd6,
        S_PRE_REMAP  = 4'd7,
        S_REMAP      = 4'd8,
        S_POST_REMAP = 4'd9,
        S_DONE       = 4'd10
    } state_t;

    state_t                 r_state;
    logic [SW-1:0]          r_step;
    logic [RW-1:0]          r_round;
    logic [RW-1:0]          r_total;
    logic [EXP_WIDTH-1:0]   r_exp;
    logic [RW-1:0]          w_lz_rounds;
    logic                   w_step_last;

    // Rounds needed to cover the highest set exponent bit; zero exponent still runs one round.
    always_comb begin
        w_lz_rounds = RW'(1);
        for (int i = 0; i < EXP_WIDTH; i++) begin
            if (expE[i]) begin
                w_lz_rounds = RW'(i + 1);
            end
        end
    end

    assign w_step_last = (r_step == c_STEP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_round <= '0;
            r_total <= '0;
            r_exp   <= '0;
        end else if (ena) begin
            if (abort && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_step  <= '0;
                r_round <= '0;
                r_exp   <= '0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            r_state <= S_PRE_MAP;
                            r_exp   <= expE;
                            r_total <= skip_lz ? w_lz_rounds : c_ROUNDS_FULL;
                            r_step  <= '0;
                            r_round <= '0;
                        end
                    end
                    S_PRE_MAP:   r_state <= S_MAP;
                    S_MAP: begin
                        r_step <= w_step_last ? '0 : r_step + SW'(1);
                        if (w_step_last) r_state <= S_POST_MAP;
                    end
                    S_POST_MAP: begin
                        r_step  <= '0;
                        r_round <= '0;
                        r_state <= S_PRE_MMM;
                    end
                    S_PRE_MMM:   r_state <= S_MMM;
                    S_MMM: begin
                        r_step <= w_step_last ? '0 : r_step + SW'(1);
                        if (w_step_last) r_state <= S_POST_MMM;
                    end
                    S_POST_MMM: begin
                        r_step  <= '0;
                        r_exp   <= r_exp >> 1;
                        r_round <= r_round + RW'(1);
                        r_state <= (r_round == r_total - RW'(1)) ? S_PRE_REMAP : S_PRE_MMM;
                    end
                    S_PRE_REMAP: r_state <= S_REMAP;
                    S_REMAP: begin
                        r_step <= w_step_last ? '0 : r_step + SW'(1);
                        if (w_step_last) r_state <= S_POST_REMAP;
                    end
                    S_POST_REMAP: r_state <= S_DONE;
                    default:      r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Outputs decode only the state and the current exponent bit.
    always_comb begin
        {rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2} = 8'b0000_0000;
        busy = 1'b0;
        eoc  = 1'b0;
        case (r_state)
            S_PRE_MAP, S_MAP: begin
                {rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2} = 8'b1101_1000;
                busy = 1'b1;
            end
            S_POST_MAP: begin
                {rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2} = 8'b1011_1000;
                busy = 1'b1;
            end
            S_PRE_MMM: begin
                {rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2} = {3'b110, r_exp[0], 4'b1011};
                busy = 1'b1;
            end
            S_MMM: begin
                {rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2} = {3'b100, r_exp[0], 4'b1011};
                busy = 1'b1;
            end
            S_POST_MMM: begin
                {rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2} = {3'b101, r_exp[0], 4'b1011};
                busy = 1'b1;
            end
            S_PRE_REMAP: begin
                {rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2} = 8'b1101_0101;
                busy = 1'b1;
            end
            S_REMAP: begin
                {rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2} = 8'b1001_0101;
                busy = 1'b1;
            end
            S_POST_REMAP: begin
                {rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2} = 8'b1011_0101;
                busy = 1'b1;
            end
            S_DONE: begin
                {rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2} = 8'b1001_0101;
                eoc = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_fsm_control_unit_param.sv
// ============================================================================
// Module   : tb_fsm_control_unit_param
// Purpose  : Directed self-checking bench for fsm_control_unit_param.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fsm_control_unit_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       skip_lz = 1'b0;
    logic [9:0] expE = '0;
    logic       rst_mmm, ld_a, ld_r, lock1, lock2, sel2, busy, eoc;
    logic [1:0] sel1;
    logic [7:0] outs;

    int checks = 0;
    int errors = 0;
    int n, nr, ones;
    logic [15:0] locks;

    localparam logic [7:0] c_PRE_MAP  = 8'b1101_1000;
    localparam logic [7:0] c_MAP      = 8'b1101_1000;
    localparam logic [7:0] c_REMAP    = 8'b1001_0101;
    localparam logic [7:0] c_DONE     = 8'b1001_0101;
    localparam logic [7:0] c_MMM_E0   = 8'b1000_1011;
    localparam logic [7:0] c_MMM_E1   = 8'b1001_1011;

    fsm_control_unit_param #(.WIDTH(8), .EXP_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .abort(abort),
        .skip_lz(skip_lz), .expE(expE), .rst_mmm(rst_mmm), .ld_a(ld_a),
        .ld_r(ld_r), .lock1(lock1), .lock2(lock2), .sel1(sel1), .sel2(sel2),
        .busy(busy), .eoc(eoc)
    );

    assign outs = {rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drives a one-cycle start; returns at the first sample after the accepting edge.
    task automatic pulse_start(input logic [9:0] e, input logic s);
        expE    = e;
        skip_lz = s;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Sample index 1 is the cycle right after the accepting edge; returns the index where eoc is first seen.
    task automatic track(input int frz_at, input logic [7:0] frz_exp,
                         output int cnt, output logic [15:0] lk, output int rounds, output int one_cnt);
        cnt = 1; lk = '0; rounds = 0; one_cnt = 0;
        while (eoc !== 1'b1 && cnt < 400) begin
            if (ld_a === 1'b1 && sel1 === 2'b01) begin
                if (rounds < 16) lk[rounds] = lock1;
                rounds++;
            end
            if (sel1 === 2'b01 && lock1 === 1'b1) one_cnt++;
            if (cnt == frz_at) begin
                ena = 1'b0;
                for (int k = 0; k < 7; k++) begin
                    @(negedge clk);
                    cnt++;
                    chk("freeze_hold", {23'd0, busy, outs}, {23'd0, 1'b1, frz_exp});
                end
                ena = 1'b1;
            end
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        // Reset must take effect even with ena low.
        repeat (2) @(negedge clk);
        chk("reset_outs", {22'd0, busy, eoc, outs}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_start", {22'd0, busy, eoc, outs}, 32'd0);
        ena = 1'b1;

        // Full-length run, no leading-zero skip.
        pulse_start(10'h2B5, 1'b0);
        chk("A_busy_first", {23'd0, busy, outs}, {23'd0, 1'b1, c_PRE_MAP});
        track(-1, 8'h00, n, locks, nr, ones);
        chk("A_latency", n, 157);
        chk("A_rounds", nr, 10);
        chk("A_lock1_seq", {16'd0, locks}, 32'h2B5);
        chk("A_done_outs", {22'd0, busy, eoc, outs}, {22'd0, 2'b01, c_DONE});

        // Restart from DONE with skip: R = 3.
        pulse_start(10'h005, 1'b1);
        chk("B_eoc_drops", {30'd0, busy, eoc}, 32'd2);
        track(-1, 8'h00, n, locks, nr, ones);
        chk("B_latency", n, 66);
        chk("B_rounds", nr, 3);
        chk("B_lock1_seq", {16'd0, locks}, 32'h5);

        // Zero exponent with skip: one round, lock1 never set.
        pulse_start(10'h000, 1'b1);
        track(-1, 8'h00, n, locks, nr, ones);
        chk("C_latency", n, 40);
        chk("C_rounds", nr, 1);
        chk("C_lock1_ones", ones, 0);

        // Abort beats start in DONE.
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("abort_over_start", {22'd0, busy, eoc, outs}, 32'd0);

        // Start with ena low is ignored.
        ena = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; ena = 1'b1;
        @(negedge clk);
        chk("start_no_ena", {22'd0, busy, eoc, outs}, 32'd0);

        // Freeze for 7 cycles inside round 1 MMM (exponent bit 1 of 2B5 is 0).
        pulse_start(10'h2B5, 1'b0);
        track(30, c_MMM_E0, n, locks, nr, ones);
        chk("D_latency", n, 164);
        chk("D_lock1_seq", {16'd0, locks}, 32'h2B5);

        // Abort during round 4, then a fresh full run.
        pulse_start(10'h3FF, 1'b0);
        for (int k = 1; k < 70; k++) @(negedge clk);
        chk("E_in_round4", {23'd0, busy, outs}, {23'd0, 1'b1, c_MMM_E1});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("E_abort_idle", {22'd0, busy, eoc, outs}, 32'd0);
        repeat (2) @(negedge clk);
        chk("E_stays_idle", {22'd0, busy, eoc, outs}, 32'd0);
        pulse_start(10'h155, 1'b0);
        track(-1, 8'h00, n, locks, nr, ones);
        chk("E_latency", n, 157);
        chk("E_lock1_seq", {16'd0, locks}, 32'h155);

        // Start held through busy never restarts; reset mid-REMAP wins.
        expE = 10'h2B5; skip_lz = 1'b0; start = 1'b1;
        @(negedge clk);
        for (int k = 1; k < 5; k++) @(negedge clk);
        chk("F_map_held", {23'd0, busy, outs}, {23'd0, 1'b1, c_MAP});
        for (int k = 5; k < 145; k++) @(negedge clk);
        chk("F_remap_held", {22'd0, busy, eoc, outs}, {22'd0, 2'b10, c_REMAP});
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("F_reset_wins", {22'd0, busy, eoc, outs}, 32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("F_idle_after", {22'd0, busy, eoc, outs}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
